sr_jk_register_bank: RTL

Parametrised, clocked successor to the single-bit cross-coupled SR latch. It provides WIDTH independent storage bits sharing one clock, with a run-time selectable flip-flop mode (SR, JK, D, T), synchronous parallel load, and complementary outputs. It also detects the forbidden SR input combination and counts those events. It sits in the lab datapath as the general-purpose state-holding element for counters, shift experiments and control flags.

---
 rtl/sr_jk_register_bank_if.sv | 34 +++
 rtl/sr_jk_register_bank.sv | 113 +++++++++++
 2 files changed

// File: rtl/sr_jk_register_bank_if.sv
// -----------------------------------------------------------------------------
// sr_jk_register_bank_if
// Purpose : bundles the control, data and status signals of the SR/JK register
//           bank so that the bank and its driver share one typed connection.
// Signals : en, mode, a, b, load, load_data, clr_err  -- driven by the master
//           q, q_bar, illegal, illegal_cnt             -- driven by the bank
// Modports: master (datapath/testbench side), slave (register bank side)
// -----------------------------------------------------------------------------
interface sr_jk_register_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output en, mode, a, b, load, load_data, clr_err,
    input  q, q_bar, illegal, illegal_cnt
  );

  modport slave (
    input  en, mode, a, b, load, load_data, clr_err,
    output q, q_bar, illegal, illegal_cnt
  );
endinterface

// File: rtl/sr_jk_register_bank.sv
// -----------------------------------------------------------------------------
// sr_jk_register_bank
// Purpose : WIDTH independent storage bits with run-time selectable flip-flop
//           behaviour (SR, JK, D, T), synchronous parallel load, complementary
//           outputs and detection/counting of the forbidden SR input (S=R=1).
// Ports   : clk    - sole clock, rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - slave side of sr_jk_register_bank_if
//                    inputs : en, mode, a, b, load, load_data, clr_err
//                    outputs: q, q_bar (= ~q), illegal, illegal_cnt
// -----------------------------------------------------------------------------
module sr_jk_register_bank #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sr_jk_register_bank_if.slave  bus
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             illegal_q;
  logic             illegal_d;
  logic [CNT_W-1:0] illegal_cnt_q;
  logic [CNT_W-1:0] illegal_cnt_d;
  logic             illegal_evt_s;

  // Forbidden SR combination: any bit with S=R=1 while the SR logic is active.
  always_comb begin
    illegal_evt_s = 1'b0;
    if (bus.en && !bus.load && (bus.mode == MODE_SR)) begin
      illegal_evt_s = |(bus.a & bus.b);
    end else begin
      illegal_evt_s = 1'b0;
    end
  end

  // Storage next state: load beats enable, enable beats hold.
  always_comb begin
    q_d = q_q;
    if (bus.load) begin
      q_d = bus.load_data;
    end else if (bus.en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (bus.mode)
          MODE_SR: begin
            // S=R=1 is defined as hold, so the bit can never go undefined.
            case ({bus.a[i], bus.b[i]})
              2'b10:   q_d[i] = 1'b1;
              2'b01:   q_d[i] = 1'b0;
              default: q_d[i] = q_q[i];
            endcase
          end
          MODE_JK: begin
            case ({bus.a[i], bus.b[i]})
              2'b10:   q_d[i] = 1'b1;
              2'b01:   q_d[i] = 1'b0;
              2'b11:   q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
          MODE_D:  q_d[i] = bus.a[i];
          MODE_T:  q_d[i] = q_q[i] ^ bus.a[i];
          default: q_d[i] = q_q[i];
        endcase
      end
    end else begin
      q_d = q_q;
    end
  end

  // Illegal pulse and saturating counter next state; clear wins over count.
  always_comb begin
    illegal_d     = illegal_evt_s;
    illegal_cnt_d = illegal_cnt_q;
    if (bus.clr_err) begin
      illegal_cnt_d = {CNT_W{1'b0}};
    end else if (illegal_evt_s && (illegal_cnt_q != CNT_MAX)) begin
      illegal_cnt_d = illegal_cnt_q + CNT_ONE;
    end else begin
      illegal_cnt_d = illegal_cnt_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q           <= {WIDTH{1'b0}};
      illegal_q     <= 1'b0;
      illegal_cnt_q <= {CNT_W{1'b0}};
    end else begin
      q_q           <= q_d;
      illegal_q     <= illegal_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // q_bar is derived from the register so it stays complementary even in reset.
  assign bus.q           = q_q;
  assign bus.q_bar       = ~q_q;
  assign bus.illegal     = illegal_q;
  assign bus.illegal_cnt = illegal_cnt_q;

endmodule
